toggle_monitor: RTL and testbench

//  Receive-side checker for a free-running square wave such as a toggling DUT output.

---
 rtl/toggle_monitor_if.sv | 43 ++++
 rtl/toggle_monitor.sv | 153 +++++++++++++++
 tb/tb_toggle_monitor.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/toggle_monitor_if.sv
// Bundle of control inputs and measurement outputs for toggle_monitor.
// With TOGGLE_MON_INV_CHECK_EN defined it also carries ref_in/inv_err.
interface toggle_monitor_if #(
    parameter int CNT_W = 16
);
    logic             en;
    logic             clr;
    logic             sig_in;
    logic [CNT_W-1:0] half_period;
    logic             period_valid;
    logic [CNT_W-1:0] edge_count;
    logic             err_short;
    logic             err_long;
    logic             err_stall;
`ifdef TOGGLE_MON_INV_CHECK_EN
    logic             ref_in;
    logic             inv_err;

    modport master (
        output en, clr, sig_in, ref_in,
        input  half_period, period_valid, edge_count,
        input  err_short, err_long, err_stall, inv_err
    );

    modport slave (
        input  en, clr, sig_in, ref_in,
        output half_period, period_valid, edge_count,
        output err_short, err_long, err_stall, inv_err
    );
`else
    modport master (
        output en, clr, sig_in,
        input  half_period, period_valid, edge_count,
        input  err_short, err_long, err_stall
    );

    modport slave (
        input  en, clr, sig_in,
        output half_period, period_valid, edge_count,
        output err_short, err_long, err_stall
    );
`endif
endinterface

// File: rtl/toggle_monitor.sv
// Square-wave half-period checker: syncs sig_in, times edge-to-edge intervals, flags short/long/stall.
// Optional TOGGLE_MON_INV_CHECK_EN adds an inverse-of-ref_in check (ref_in/inv_err).
module toggle_monitor #(
    parameter int CNT_W    = 16,
    parameter int EXP_HALF = 10,
    parameter int TOL      = 1,
    parameter int TIMEOUT  = 64
) (
    input  logic            clk,
    input  logic            rst,
    toggle_monitor_if.slave mon
);
    typedef enum logic [1:0] {IDLE, WAIT_FIRST, MEASURE, STALL} state_t;

    localparam logic [CNT_W:0]   LOW_BOUND  = (EXP_HALF >= TOL) ? (CNT_W+1)'(EXP_HALF - TOL) : '0;
    localparam logic [CNT_W:0]   HIGH_BOUND = (CNT_W+1)'(EXP_HALF + TOL);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_SAT    = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] EC_MAX     = '1;

    state_t           state, state_nxt;
    logic             s1, s2, s3;
    logic             sig_edge;
    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
    logic [CNT_W-1:0] hp_r, hp_nxt;
    logic             pv_r, pv_nxt;
    logic [CNT_W-1:0] ec_r, ec_nxt, ec_base;
    logic             short_r, short_nxt;
    logic             long_r, long_nxt;
    logic             stall_r, stall_nxt;
    logic             count_edge, set_short, set_long, set_stall;

    assign sig_edge = s2 ^ s3;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            s1      <= 1'b0;
            s2      <= 1'b0;
            s3      <= 1'b0;
            cnt     <= '0;
            hp_r    <= '0;
            pv_r    <= 1'b0;
            ec_r    <= '0;
            short_r <= 1'b0;
            long_r  <= 1'b0;
            stall_r <= 1'b0;
        end else begin
            state   <= state_nxt;
            s1      <= mon.sig_in;
            s2      <= s1;
            s3      <= s2;
            cnt     <= cnt_nxt;
            hp_r    <= hp_nxt;
            pv_r    <= pv_nxt;
            ec_r    <= ec_nxt;
            short_r <= short_nxt;
            long_r  <= long_nxt;
            stall_r <= stall_nxt;
        end
    end

    // An edge always beats a timeout in the same cycle, so edge handling is tested first.
    always_comb begin
        state_nxt  = state;
        cnt_inc    = (cnt >= CNT_SAT) ? cnt : cnt + CNT_W'(1);
        cnt_nxt    = cnt;
        hp_nxt     = hp_r;
        pv_nxt     = 1'b0;
        count_edge = 1'b0;
        set_short  = 1'b0;
        set_long   = 1'b0;
        set_stall  = 1'b0;
        if (!mon.en) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt_nxt   = '0;
                    state_nxt = WAIT_FIRST;
                end
                WAIT_FIRST, MEASURE: begin
                    if (sig_edge) begin
                        state_nxt  = MEASURE;
                        cnt_nxt    = CNT_W'(1);
                        count_edge = 1'b1;
                        if (state == MEASURE) begin
                            hp_nxt    = cnt;
                            pv_nxt    = 1'b1;
                            set_short = ({1'b0, cnt} < LOW_BOUND);
                            set_long  = ({1'b0, cnt} > HIGH_BOUND);
                        end
                    end else begin
                        cnt_nxt = cnt_inc;
                        if (cnt == CNT_LAST) begin
                            state_nxt = STALL;
                            set_stall = 1'b1;
                        end
                    end
                end
                STALL: begin
                    if (sig_edge) begin
                        state_nxt  = MEASURE;
                        cnt_nxt    = CNT_W'(1);
                        count_edge = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
        // A clear and a same-cycle set resolve in favour of the set.
        ec_base   = mon.clr ? '0 : ec_r;
        ec_nxt    = (count_edge && ec_base != EC_MAX) ? ec_base + CNT_W'(1) : ec_base;
        short_nxt = (mon.clr ? 1'b0 : short_r) | set_short;
        long_nxt  = (mon.clr ? 1'b0 : long_r)  | set_long;
        stall_nxt = (mon.clr ? 1'b0 : stall_r) | set_stall;
    end

    assign mon.half_period  = hp_r;
    assign mon.period_valid = pv_r;
    assign mon.edge_count   = ec_r;
    assign mon.err_short    = short_r;
    assign mon.err_long     = long_r;
    assign mon.err_stall    = stall_r;

`ifdef TOGGLE_MON_INV_CHECK_EN
    logic       r1, r2;
    logic [1:0] match_run;
    logic       inv_r;
    logic       same_now, inv_set;

    // Two sync stages keep r2 aligned with s2 so the comparison sees matched samples.
    assign same_now = mon.en && (state == MEASURE) && (s2 == r2);
    assign inv_set  = same_now && (match_run == 2'd2);

    always_ff @(posedge clk) begin
        if (rst) begin
            r1        <= 1'b0;
            r2        <= 1'b0;
            match_run <= 2'd0;
            inv_r     <= 1'b0;
        end else begin
            r1        <= mon.ref_in;
            r2        <= r1;
            match_run <= same_now ? ((match_run == 2'd2) ? 2'd2 : match_run + 2'd1) : 2'd0;
            inv_r     <= (mon.clr ? 1'b0 : inv_r) | inv_set;
        end
    end

    assign mon.inv_err = inv_r;
`endif
endmodule

// File: tb/tb_toggle_monitor.sv
// Scoreboard bench for toggle_monitor (EXP_HALF=10, TOL=1, TIMEOUT=64).
// Inverse-check scenario is built only with TOGGLE_MON_INV_CHECK_EN.
module tb_toggle_monitor;
    localparam int CNT_W = 16;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad = 0;
    int   rd_idx = 0;
    logic [CNT_W-1:0] exp_q[$];
    logic [CNT_W-1:0] obs_q[$];

    toggle_monitor_if #(.CNT_W(CNT_W)) mif();

`ifdef TOGGLE_MON_INV_CHECK_EN
    logic inv_force = 1'b0;
    assign mif.ref_in = inv_force ? mif.sig_in : ~mif.sig_in;
`endif

    toggle_monitor #(.CNT_W(CNT_W), .EXP_HALF(10), .TOL(1), .TIMEOUT(64)) dut (
        .clk(clk),
        .rst(rst),
        .mon(mif.slave)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mif.period_valid === 1'b1) obs_q.push_back(mif.half_period);
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic edge_then_wait(input bit measured, input int exp_hp, input int gap);
        mif.sig_in = ~mif.sig_in;
        if (measured) exp_q.push_back(CNT_W'(exp_hp));
        wait_clks(gap);
    endtask

    task automatic restart();
        mif.en = 1'b0;
        mif.sig_in = 1'b0;
        wait_clks(4);
        mif.clr = 1'b1;
        wait_clks(1);
        mif.clr = 1'b0;
        mif.en = 1'b1;
        wait_clks(2);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mif.en = 1'b0;
        mif.clr = 1'b0;
        mif.sig_in = 1'b0;
        wait_clks(3);
        total += 6;
        if (mif.half_period !== '0) begin bad++; $display("[TB] FAIL reset_hp got %0d want 0", mif.half_period); end
        if (mif.period_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_pv got %b want 0", mif.period_valid); end
        if (mif.edge_count !== '0) begin bad++; $display("[TB] FAIL reset_ec got %0d want 0", mif.edge_count); end
        if (mif.err_short !== 1'b0) begin bad++; $display("[TB] FAIL reset_short got %b want 0", mif.err_short); end
        if (mif.err_long !== 1'b0) begin bad++; $display("[TB] FAIL reset_long got %b want 0", mif.err_long); end
        if (mif.err_stall !== 1'b0) begin bad++; $display("[TB] FAIL reset_stall got %b want 0", mif.err_stall); end
        rst = 1'b0;
        wait_clks(1);
    endtask

    task automatic test_nominal();
        logic [CNT_W-1:0] e;
        restart();
        edge_then_wait(1'b0, 0, 10);
        for (int i = 0; i < 4; i++) edge_then_wait(1'b1, 10, 10);
        edge_then_wait(1'b1, 10, 5);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (rd_idx >= obs_q.size()) begin bad++; $display("[TB] FAIL nominal_hp got no pulse want %0d", e); end
            else begin
                if (obs_q[rd_idx] !== e) begin bad++; $display("[TB] FAIL nominal_hp got %0d want %0d", obs_q[rd_idx], e); end
                rd_idx++;
            end
        end
        total += 5;
        if (obs_q.size() != rd_idx) begin bad++; $display("[TB] FAIL nominal_pulses got %0d want %0d", obs_q.size(), rd_idx); end
        rd_idx = obs_q.size();
        if (mif.edge_count !== 16'd6) begin bad++; $display("[TB] FAIL nominal_ec got %0d want 6", mif.edge_count); end
        if (mif.err_short !== 1'b0) begin bad++; $display("[TB] FAIL nominal_short got %b want 0", mif.err_short); end
        if (mif.err_long !== 1'b0) begin bad++; $display("[TB] FAIL nominal_long got %b want 0", mif.err_long); end
        if (mif.err_stall !== 1'b0) begin bad++; $display("[TB] FAIL nominal_stall got %b want 0", mif.err_stall); end
    endtask

    task automatic test_window_bounds();
        logic [CNT_W-1:0] e;
        restart();
        edge_then_wait(1'b0, 0, 9);
        edge_then_wait(1'b1, 9, 11);
        edge_then_wait(1'b1, 11, 5);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (rd_idx >= obs_q.size()) begin bad++; $display("[TB] FAIL bounds_hp got no pulse want %0d", e); end
            else begin
                if (obs_q[rd_idx] !== e) begin bad++; $display("[TB] FAIL bounds_hp got %0d want %0d", obs_q[rd_idx], e); end
                rd_idx++;
            end
        end
        total += 4;
        if (obs_q.size() != rd_idx) begin bad++; $display("[TB] FAIL bounds_pulses got %0d want %0d", obs_q.size(), rd_idx); end
        rd_idx = obs_q.size();
        if (mif.err_short !== 1'b0) begin bad++; $display("[TB] FAIL bounds_short got %b want 0", mif.err_short); end
        if (mif.err_long !== 1'b0) begin bad++; $display("[TB] FAIL bounds_long got %b want 0", mif.err_long); end
        if (mif.edge_count !== 16'd3) begin bad++; $display("[TB] FAIL bounds_ec got %0d want 3", mif.edge_count); end
    endtask

    task automatic test_short();
        logic [CNT_W-1:0] e;
        restart();
        edge_then_wait(1'b0, 0, 7);
        edge_then_wait(1'b1, 7, 5);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (rd_idx >= obs_q.size()) begin bad++; $display("[TB] FAIL short_hp got no pulse want %0d", e); end
            else begin
                if (obs_q[rd_idx] !== e) begin bad++; $display("[TB] FAIL short_hp got %0d want %0d", obs_q[rd_idx], e); end
                rd_idx++;
            end
        end
        total += 3;
        if (obs_q.size() != rd_idx) begin bad++; $display("[TB] FAIL short_pulses got %0d want %0d", obs_q.size(), rd_idx); end
        rd_idx = obs_q.size();
        if (mif.err_short !== 1'b1) begin bad++; $display("[TB] FAIL short_flag got %b want 1", mif.err_short); end
        if (mif.err_long !== 1'b0) begin bad++; $display("[TB] FAIL short_long got %b want 0", mif.err_long); end
    endtask

    task automatic test_long_and_clear();
        logic [CNT_W-1:0] e;
        restart();
        edge_then_wait(1'b0, 0, 12);
        edge_then_wait(1'b1, 12, 5);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (rd_idx >= obs_q.size()) begin bad++; $display("[TB] FAIL long_hp got no pulse want %0d", e); end
            else begin
                if (obs_q[rd_idx] !== e) begin bad++; $display("[TB] FAIL long_hp got %0d want %0d", obs_q[rd_idx], e); end
                rd_idx++;
            end
        end
        total += 3;
        if (obs_q.size() != rd_idx) begin bad++; $display("[TB] FAIL long_pulses got %0d want %0d", obs_q.size(), rd_idx); end
        rd_idx = obs_q.size();
        if (mif.err_long !== 1'b1) begin bad++; $display("[TB] FAIL long_flag got %b want 1", mif.err_long); end
        if (mif.err_short !== 1'b0) begin bad++; $display("[TB] FAIL long_short got %b want 0", mif.err_short); end
        mif.clr = 1'b1;
        wait_clks(1);
        mif.clr = 1'b0;
        total += 2;
        if (mif.err_long !== 1'b0) begin bad++; $display("[TB] FAIL clr_long got %b want 0", mif.err_long); end
        if (mif.edge_count !== '0) begin bad++; $display("[TB] FAIL clr_ec got %0d want 0", mif.edge_count); end
    endtask

    task automatic test_stall();
        logic [CNT_W-1:0] e;
        restart();
        edge_then_wait(1'b0, 0, 30);
        total++;
        if (mif.err_stall !== 1'b0) begin bad++; $display("[TB] FAIL stall_early got %b want 0", mif.err_stall); end
        wait_clks(40);
        total++;
        if (mif.err_stall !== 1'b1) begin bad++; $display("[TB] FAIL stall_flag got %b want 1", mif.err_stall); end
        edge_then_wait(1'b0, 0, 10);
        edge_then_wait(1'b1, 10, 5);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (rd_idx >= obs_q.size()) begin bad++; $display("[TB] FAIL stall_hp got no pulse want %0d", e); end
            else begin
                if (obs_q[rd_idx] !== e) begin bad++; $display("[TB] FAIL stall_hp got %0d want %0d", obs_q[rd_idx], e); end
                rd_idx++;
            end
        end
        total += 3;
        if (obs_q.size() != rd_idx) begin bad++; $display("[TB] FAIL stall_pulses got %0d want %0d", obs_q.size(), rd_idx); end
        rd_idx = obs_q.size();
        if (mif.edge_count !== 16'd3) begin bad++; $display("[TB] FAIL stall_ec got %0d want 3", mif.edge_count); end
        if (mif.err_stall !== 1'b1) begin bad++; $display("[TB] FAIL stall_sticky got %b want 1", mif.err_stall); end
    endtask

    task automatic test_reset_mid();
        logic [CNT_W-1:0] e;
        restart();
        edge_then_wait(1'b0, 0, 10);
        edge_then_wait(1'b1, 10, 5);
        rst = 1'b1;
        wait_clks(1);
        total += 4;
        if (mif.half_period !== '0) begin bad++; $display("[TB] FAIL rstmid_hp got %0d want 0", mif.half_period); end
        if (mif.edge_count !== '0) begin bad++; $display("[TB] FAIL rstmid_ec got %0d want 0", mif.edge_count); end
        if (mif.period_valid !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_pv got %b want 0", mif.period_valid); end
        if ({mif.err_short, mif.err_long, mif.err_stall} !== 3'b000) begin
            bad++; $display("[TB] FAIL rstmid_errs got %b want 000", {mif.err_short, mif.err_long, mif.err_stall});
        end
        rst = 1'b0;
        wait_clks(1);
        edge_then_wait(1'b0, 0, 10);
        edge_then_wait(1'b1, 10, 5);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (rd_idx >= obs_q.size()) begin bad++; $display("[TB] FAIL rstmid_hpq got no pulse want %0d", e); end
            else begin
                if (obs_q[rd_idx] !== e) begin bad++; $display("[TB] FAIL rstmid_hpq got %0d want %0d", obs_q[rd_idx], e); end
                rd_idx++;
            end
        end
        total += 2;
        if (obs_q.size() != rd_idx) begin bad++; $display("[TB] FAIL rstmid_pulses got %0d want %0d", obs_q.size(), rd_idx); end
        rd_idx = obs_q.size();
        if (mif.edge_count !== 16'd2) begin bad++; $display("[TB] FAIL rstmid_ec2 got %0d want 2", mif.edge_count); end
    endtask

`ifdef TOGGLE_MON_INV_CHECK_EN
    task automatic test_inv_check();
        logic [CNT_W-1:0] e;
        restart();
        edge_then_wait(1'b0, 0, 10);
        edge_then_wait(1'b1, 10, 10);
        total++;
        if (mif.inv_err !== 1'b0) begin bad++; $display("[TB] FAIL inv_idle got %b want 0", mif.inv_err); end
        inv_force = 1'b1;
        wait_clks(2);
        inv_force = 1'b0;
        wait_clks(5);
        total++;
        if (mif.inv_err !== 1'b0) begin bad++; $display("[TB] FAIL inv_two got %b want 0", mif.inv_err); end
        inv_force = 1'b1;
        wait_clks(3);
        inv_force = 1'b0;
        wait_clks(5);
        total++;
        if (mif.inv_err !== 1'b1) begin bad++; $display("[TB] FAIL inv_three got %b want 1", mif.inv_err); end
        mif.clr = 1'b1;
        wait_clks(1);
        mif.clr = 1'b0;
        total++;
        if (mif.inv_err !== 1'b0) begin bad++; $display("[TB] FAIL inv_clr got %b want 0", mif.inv_err); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (rd_idx >= obs_q.size()) begin bad++; $display("[TB] FAIL inv_hp got no pulse want %0d", e); end
            else begin
                if (obs_q[rd_idx] !== e) begin bad++; $display("[TB] FAIL inv_hp got %0d want %0d", obs_q[rd_idx], e); end
                rd_idx++;
            end
        end
        total++;
        if (obs_q.size() != rd_idx) begin bad++; $display("[TB] FAIL inv_pulses got %0d want %0d", obs_q.size(), rd_idx); end
        rd_idx = obs_q.size();
    endtask
`endif

    initial begin
        test_reset();
        test_nominal();
        test_window_bounds();
        test_short();
        test_long_and_clear();
        test_stall();
        test_reset_mid();
`ifdef TOGGLE_MON_INV_CHECK_EN
        test_inv_check();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
